// File: rtl/line_tool.sv
// line_tool: rubber-band Bresenham line generator streaming one pixel per clock
module line_tool #(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int COLOR_WIDTH = 3,
  parameter logic [COLOR_WIDTH-1:0] COLOR_NONE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [$clog2(WIDTH)-1:0]   cursor_x,
  input  logic [$clog2(HEIGHT)-1:0]  cursor_y,
  input  logic [COLOR_WIDTH-1:0]     input_color,
  output logic [$clog2(WIDTH)-1:0]   pixel_x,
  output logic [$clog2(HEIGHT)-1:0]  pixel_y,
  output logic [COLOR_WIDTH-1:0]     pixel_color,
  output logic                       pixel_valid,
  output logic                       busy
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = (XW > YW ? XW : YW) + 2;
  typedef enum logic [1:0] {IDLE, ANCHOR, SETUP, DRAW} state_t;
  state_t state_q, state_d;
  logic [XW-1:0] x0_q, x0_d, x1_q, x1_d, x_q, x_d, pixel_x_q, pixel_x_d;
  logic [YW-1:0] y0_q, y0_d, y1_q, y1_d, y_q, y_d, pixel_y_q, pixel_y_d;
  logic [COLOR_WIDTH-1:0] color_q, color_d, pixel_color_q, pixel_color_d;
  logic signed [CW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d, e2;
  logic sx_q, sx_d, sy_q, sy_d, pixel_valid_q, pixel_valid_d, busy_q, busy_d;
  logic step_x, step_y;
  assign pixel_x = pixel_x_q;
  assign pixel_y = pixel_y_q;
  assign pixel_color = pixel_color_q;
  assign pixel_valid = pixel_valid_q;
  assign busy = busy_q;
  // Next-state, Bresenham stepping and registered output values
  always_comb begin
    state_d = state_q;
    x0_d = x0_q;
    y0_d = y0_q;
    x1_d = x1_q;
    y1_d = y1_q;
    x_d = x_q;
    y_d = y_q;
    color_d = color_q;
    dx_d = dx_q;
    dy_d = dy_q;
    err_d = err_q;
    sx_d = sx_q;
    sy_d = sy_q;
    pixel_x_d = pixel_x_q;
    pixel_y_d = pixel_y_q;
    pixel_color_d = COLOR_NONE;
    pixel_valid_d = 1'b0;
    e2 = err_q <<< 1;
    step_x = e2 >= dy_q;
    step_y = e2 <= dx_q;
    case (state_q)
      IDLE: if (enable) begin
        x0_d = cursor_x;
        y0_d = cursor_y;
        color_d = input_color;
        state_d = ANCHOR;
      end
      ANCHOR: if (!enable) begin
        x1_d = cursor_x;
        y1_d = cursor_y;
        state_d = SETUP;
      end
      SETUP: begin
        sx_d = x0_q < x1_q;
        sy_d = y0_q < y1_q;
        dx_d = sx_d ? CW'(x1_q) - CW'(x0_q) : CW'(x0_q) - CW'(x1_q);
        dy_d = sy_d ? CW'(y0_q) - CW'(y1_q) : CW'(y1_q) - CW'(y0_q);
        err_d = dx_d + dy_d;
        x_d = x0_q;
        y_d = y0_q;
        state_d = DRAW;
      end
      DRAW: begin
        pixel_x_d = x_q;
        pixel_y_d = y_q;
        pixel_color_d = color_q;
        pixel_valid_d = 1'b1;
        if (x_q == x1_q && y_q == y1_q) state_d = IDLE;
        else begin
          err_d = err_q + (step_x ? dy_q : CW'(0)) + (step_y ? dx_q : CW'(0));
          x_d = step_x ? (sx_q ? x_q + XW'(1) : x_q - XW'(1)) : x_q;
          y_d = step_y ? (sy_q ? y_q + YW'(1) : y_q - YW'(1)) : y_q;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d == SETUP || state_q == SETUP || state_q == DRAW;
  end
  // State and output registers; reset abandons any line in progress at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x0_q <= '0;
      y0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      x_q <= '0;
      y_q <= '0;
      color_q <= COLOR_NONE;
      dx_q <= '0;
      dy_q <= '0;
      err_q <= '0;
      sx_q <= 1'b0;
      sy_q <= 1'b0;
      pixel_x_q <= '0;
      pixel_y_q <= '0;
      pixel_color_q <= COLOR_NONE;
      pixel_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q <= x0_d;
      y0_q <= y0_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
      x_q <= x_d;
      y_q <= y_d;
      color_q <= color_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      err_q <= err_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      pixel_x_q <= pixel_x_d;
      pixel_y_q <= pixel_y_d;
      pixel_color_q <= pixel_color_d;
      pixel_valid_q <= pixel_valid_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_line_tool.sv
// tb_line_tool: directed line scenarios with a pixel scoreboard
module tb_line_tool;
  localparam logic [2:0] NONE = 3'd0;
  localparam logic [2:0] C1 = 3'd5;
  localparam logic [2:0] C2 = 3'd2;
  localparam logic [2:0] C3 = 3'd6;
  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] c;
  } pix_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [9:0] cursor_x = '0;
  logic [8:0] cursor_y = '0;
  logic [2:0] input_color = NONE;
  logic [9:0] pixel_x;
  logic [8:0] pixel_y;
  logic [2:0] pixel_color;
  logic pixel_valid;
  logic busy;
  pix_t exp_q[$];
  int checks = 0;
  int errors = 0;
  line_tool dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .cursor_x(cursor_x),
    .cursor_y(cursor_y),
    .input_color(input_color),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .pixel_color(pixel_color),
    .pixel_valid(pixel_valid),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input int x, input int y, input logic [2:0] c);
    pix_t p;
    p.x = 10'(x);
    p.y = 9'(y);
    p.c = c;
    exp_q.push_back(p);
  endtask
  // Advance one edge, then score any pixel the DUT presents
  task automatic tick();
    pix_t p;
    @(posedge clk);
    #1;
    if (pixel_valid) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL extra_pixel: observed (%0d,%0d) expected none", pixel_x, pixel_y);
      end
      if (exp_q.size() > 0) begin
        p = exp_q.pop_front();
        chk("pixel", {pixel_x, pixel_y, pixel_color}, {p.x, p.y, p.c});
      end
    end
  endtask
  task automatic press(input int x, input int y, input logic [2:0] c);
    cursor_x = 10'(x);
    cursor_y = 9'(y);
    input_color = c;
    enable = 1'b1;
    tick();
  endtask
  task automatic release_at(input int x, input int y);
    cursor_x = 10'(x);
    cursor_y = 9'(y);
    enable = 1'b0;
    tick();
  endtask
  // After the release edge: SETUP, one silent DRAW cycle, n pixels, then idle
  task automatic run(input int n);
    chk("setup_busy", 32'(busy), 1);
    chk("setup_valid", 32'(pixel_valid), 0);
    tick();
    chk("latency_valid", 32'(pixel_valid), 0);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("stream_valid", 32'(pixel_valid), 1);
      chk("stream_busy", 32'(busy), 1);
    end
    tick();
    chk("end_valid", 32'(pixel_valid), 0);
    chk("end_busy", 32'(busy), 0);
    chk("end_color", 32'(pixel_color), 32'(NONE));
    chk("end_queue", 32'(exp_q.size()), 0);
  endtask
  initial begin
    tick();
    chk("rst_valid", 32'(pixel_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_color", 32'(pixel_color), 32'(NONE));
    chk("rst_xy", {13'd0, pixel_x, pixel_y}, 0);
    reset = 1'b0;
    tick();
    // Horizontal line; cursor motion while held is ignored
    press(2, 3, C1);
    cursor_x = 10'd30;
    cursor_y = 9'd30;
    tick();
    chk("anchor_busy", 32'(busy), 0);
    release_at(5, 3);
    for (int i = 2; i <= 5; i++) push(i, 3, C1);
    run(4);
    chk("hold_xy", {13'd0, pixel_x, pixel_y}, {13'd0, 10'd5, 9'd3});
    // Reversed vertical line
    press(6, 7, C2);
    release_at(6, 1);
    for (int i = 7; i >= 1; i--) push(6, i, C2);
    run(7);
    // Steep line
    press(0, 0, C1);
    release_at(2, 5);
    push(0, 0, C1);
    push(0, 1, C1);
    push(1, 2, C1);
    push(1, 3, C1);
    push(2, 4, C1);
    push(2, 5, C1);
    run(6);
    // Single point; color changes after the press are ignored
    press(4, 4, C3);
    input_color = C1;
    tick();
    release_at(4, 4);
    push(4, 4, C3);
    run(1);
    // Asynchronous reset after the third pixel of a diagonal
    press(0, 0, C2);
    release_at(7, 7);
    for (int i = 0; i < 3; i++) push(i, i, C2);
    tick();
    tick();
    tick();
    tick();
    chk("pre_reset_valid", 32'(pixel_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", 32'(pixel_valid), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_color", 32'(pixel_color), 32'(NONE));
    chk("reset_queue", 32'(exp_q.size()), 0);
    #2 reset = 1'b0;
    repeat (20) tick();
    chk("post_reset_busy", 32'(busy), 0);
    // Button pressed during DRAW and held through completion re-anchors
    press(0, 0, C1);
    release_at(3, 0);
    for (int i = 0; i <= 3; i++) push(i, 0, C1);
    tick();
    enable = 1'b1;
    cursor_x = 10'd9;
    cursor_y = 9'd9;
    input_color = C2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_valid", 32'(pixel_valid), 1);
    end
    cursor_x = 10'd12;
    cursor_y = 9'd5;
    input_color = C3;
    tick();
    chk("held_last_valid", 32'(pixel_valid), 1);
    chk("held_last_busy", 32'(busy), 1);
    tick();
    chk("reanchor_valid", 32'(pixel_valid), 0);
    chk("reanchor_busy", 32'(busy), 0);
    cursor_x = 10'd20;
    cursor_y = 9'd20;
    input_color = C1;
    repeat (3) tick();
    chk("reanchor_quiet", {30'd0, pixel_valid, busy}, 0);
    release_at(12, 8);
    for (int i = 5; i <= 8; i++) push(12, i, C3);
    run(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
